cfg_logic_cluster: RTL and testbench

//  Parametrised successor to the single 5-input logic tile: a cluster of N K-input LUT slices, each with an optional output FF.

---
 rtl/fpga_cfg_pkg.sv | 18 +
 rtl/cluster_slice.sv | 41 ++++
 rtl/cfg_logic_cluster.sv | 115 +++++++++++
 tb/tb_cfg_logic_cluster.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared types and helpers for the configurable logic cluster.
package fpga_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACTIVE
  } cfg_state_e;

  // Control bits sit directly above the truth table in each slice field
  localparam int unsigned REG_OFS  = 0;
  localparam int unsigned INIT_OFS = 1;

  function automatic int unsigned slice_bits(input int unsigned k);
    return (32'd1 << k) + 32'd2;
  endfunction

endpackage

// File: rtl/cluster_slice.sv
// One K-input LUT slice: truth-table mux plus optional output FF with init load.
module cluster_slice
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned K = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            active,
  input  logic            load_init,
  input  logic            init_val,
  input  logic            ce,
  input  logic [2**K-1:0] tt,
  input  logic            reg_sel,
  input  logic [K-1:0]    lut_in,
  output logic            lut_out
);

  logic ff_q;
  logic lut_val;

  assign lut_val = tt[lut_in];

  always_ff @(posedge clock) begin
    if (!reset) begin
      ff_q <= '0;
    end else if (load_init) begin
      ff_q <= init_val;
    end else if (active && reg_sel && ce) begin
      ff_q <= lut_val;
    end
  end

  always_comb begin
    lut_out = '0;
    if (active) begin
      lut_out = reg_sel ? ff_q : lut_val;
    end
  end

endmodule

// File: rtl/cfg_logic_cluster.sv
// Cluster of N K-input LUT slices configured through a handshaked serial shift chain.
// Optional CFG_READBACK_EN adds cfg_dout for daisy-chaining and config readback.
module cfg_logic_cluster
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned K     = 5,
  parameter int unsigned N     = 4,
  parameter int unsigned CFG_W = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
`ifdef CFG_READBACK_EN
  output logic [CFG_W-1:0] cfg_dout,
`endif
  input  logic             ce,
  input  logic [N*K-1:0]   lut_in,
  output logic [N-1:0]     lut_out
);

  localparam int unsigned TT       = 2**K;
  localparam int unsigned L        = slice_bits(K);
  localparam int unsigned CFG_BITS = N * L;
  localparam int unsigned BEATS    = CFG_BITS / CFG_W;
  localparam int unsigned CW       = $clog2(BEATS + 1);

  cfg_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CFG_BITS-1:0]  shreg_q, shreg_d;
  logic                 err_q, err_d;
  logic                 beat;
  logic                 last_beat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    err_d     = err_q;
    beat      = cfg_valid && (state_q == LOAD) && !cfg_start;
    last_beat = beat && (cnt_q == CW'(BEATS - 1));
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          cnt_d = '0;
          err_d = 1'b1;
        end else if (beat) begin
          shreg_d = CFG_BITS'({cfg_data, shreg_q} >> CFG_W);
          cnt_d   = cnt_q + CW'(1);
          if (last_beat) begin
            state_d = ACTIVE;
            err_d   = 1'b0;
          end
        end
      end
      ACTIVE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready = (state_q == LOAD);
  assign cfg_done  = (state_q == ACTIVE);
  assign cfg_err   = err_q;
`ifdef CFG_READBACK_EN
  assign cfg_dout  = shreg_q[CFG_W-1:0];
`endif

  // Init bits come from the post-shift image so the FFs load on the final-beat edge
  for (genvar j = 0; j < N; j++) begin : g_slice
    cluster_slice #(
      .K(K)
    ) u_slice (
      .clock    (clock),
      .reset    (reset),
      .active   (state_q == ACTIVE),
      .load_init(last_beat),
      .init_val (shreg_d[j*L + TT + INIT_OFS]),
      .ce       (ce),
      .tt       (shreg_q[j*L +: TT]),
      .reg_sel  (shreg_q[j*L + TT + REG_OFS]),
      .lut_in   (lut_in[j*K +: K]),
      .lut_out  (lut_out[j])
    );
  end

endmodule

// File: tb/tb_cfg_logic_cluster.sv
// Randomized self-checking bench for cfg_logic_cluster (K=5, N=4, CFG_W=2).
module tb_cfg_logic_cluster;

  localparam int unsigned K     = 5;
  localparam int unsigned N     = 4;
  localparam int unsigned CFG_W = 2;
  localparam int unsigned L     = 34;
  localparam int unsigned BEATS = 68;

  logic         clock = 1'b0;
  logic         reset;
  logic         cfg_start;
  logic         cfg_valid;
  logic [1:0]   cfg_data;
  logic         cfg_ready;
  logic         cfg_done;
  logic         cfg_err;
  logic         ce;
  logic [19:0]  lut_in;
  logic [3:0]   lut_out;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-slice configuration and FF contents
  logic [31:0]  m_tt [4];
  logic [3:0]   m_reg;
  logic [3:0]   m_ff;
  logic         m_active;
  logic [31:0]  p_tt [4];
  logic [3:0]   p_reg;
  logic [3:0]   p_init;

  always #5 clock = ~clock;

`ifdef CFG_READBACK_EN
  logic [1:0]   dout_a;
  logic [1:0]   dout_b;
  logic         start_b;
  logic         valid_b;
  logic         ready_b;
  logic         done_b;
  logic         err_b;
  logic [3:0]   lut_out_b;
  logic [135:0] patt;

  assign valid_b = cfg_valid && cfg_ready && !cfg_start;
`endif

  cfg_logic_cluster #(
    .K(K),
    .N(N),
    .CFG_W(CFG_W)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
`ifdef CFG_READBACK_EN
    .cfg_dout (dout_a),
`endif
    .ce       (ce),
    .lut_in   (lut_in),
    .lut_out  (lut_out)
  );

`ifdef CFG_READBACK_EN
  cfg_logic_cluster #(
    .K(K),
    .N(N),
    .CFG_W(CFG_W)
  ) u_dut_b (
    .clock    (clock),
    .reset    (reset),
    .cfg_start(start_b),
    .cfg_valid(valid_b),
    .cfg_data (dout_a),
    .cfg_ready(ready_b),
    .cfg_done (done_b),
    .cfg_err  (err_b),
    .cfg_dout (dout_b),
    .ce       (1'b0),
    .lut_in   (20'h0),
    .lut_out  (lut_out_b)
  );
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [135:0] pack_img();
    logic [135:0] img;
    img = '0;
    for (int j = 0; j < 4; j++) begin
      img[j*L +: 32] = p_tt[j];
      img[j*L + 32]  = p_reg[j];
      img[j*L + 33]  = p_init[j];
    end
    return img;
  endfunction

  function automatic logic [3:0] model_out();
    logic [3:0] o;
    logic [4:0] idx;
    o = '0;
    for (int j = 0; j < 4; j++) begin
      idx = lut_in[j*K +: K];
      if (m_active) o[j] = m_reg[j] ? m_ff[j] : m_tt[j][idx];
    end
    return o;
  endfunction

  task automatic tick();
    logic [3:0] nxt;
    logic [4:0] idx;
    nxt = m_ff;
    for (int j = 0; j < 4; j++) begin
      idx = lut_in[j*K +: K];
      if (m_active && m_reg[j] && ce) nxt[j] = m_tt[j][idx];
    end
    @(posedge clock);
    #1;
    m_ff = nxt;
  endtask

  task automatic randomize_cfg();
    for (int j = 0; j < 4; j++) p_tt[j] = $urandom;
    p_reg  = 4'($urandom);
    p_init = 4'($urandom);
  endtask

  task automatic do_load(input int stall_pct, input logic start_valid, input logic exp_err);
    logic [135:0] img;
    int           b;
    logic         stall;
    img       = pack_img();
    ce        = 1'b0;
    cfg_start = 1'b1;
    cfg_valid = start_valid;
    cfg_data  = ~img[1:0];
    tick();
    m_active  = 1'b0;
    cfg_start = 1'b0;
    check_eq("start_ready", 32'(cfg_ready), 32'd1);
    check_eq("start_done", 32'(cfg_done), 32'd0);
    check_eq("start_err", 32'(cfg_err), 32'(exp_err));
    check_eq("load_lut_out", 32'(lut_out), 32'd0);
    b = 0;
    while (b < int'(BEATS)) begin
      stall = ($urandom_range(99) < stall_pct);
      if (stall) begin
        cfg_valid = 1'b0;
        cfg_data  = 2'($urandom);
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = img[b*2 +: 2];
      end
      tick();
      if (!stall) begin
        b++;
        if (b == int'(BEATS) - 1) begin
          check_eq("done_before_last", 32'(cfg_done), 32'd0);
          check_eq("ready_before_last", 32'(cfg_ready), 32'd1);
        end
      end
    end
    cfg_valid = 1'b0;
    for (int j = 0; j < 4; j++) m_tt[j] = p_tt[j];
    m_reg    = p_reg;
    m_ff     = p_init;
    m_active = 1'b1;
    check_eq("done_after_load", 32'(cfg_done), 32'd1);
    check_eq("err_after_load", 32'(cfg_err), 32'd0);
    check_eq("ready_after_load", 32'(cfg_ready), 32'd0);
  endtask

  task automatic run_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      lut_in = 20'($urandom);
      ce     = 1'($urandom_range(1));
      #1;
      check_eq("rand_lut_out", 32'(lut_out), 32'(model_out()));
      tick();
    end
  endtask

  task automatic raw_beats(input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 2'($urandom);
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    ce        = 1'b0;
    lut_in    = 20'($urandom);
    m_active  = 1'b0;
    m_ff      = '0;
    m_reg     = '0;
    for (int j = 0; j < 4; j++) m_tt[j] = '0;
`ifdef CFG_READBACK_EN
    start_b   = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_eq("rst_ready", 32'(cfg_ready), 32'd0);
    check_eq("rst_done", 32'(cfg_done), 32'd0);
    check_eq("rst_err", 32'(cfg_err), 32'd0);
    check_eq("rst_lut_out", 32'(lut_out), 32'd0);
    tick();
    check_eq("idle_lut_out", 32'(lut_out), 32'd0);

    // AND5 combinational slice 0, parity registered slice 1 with init 1
    randomize_cfg();
    p_tt[0] = 32'h8000_0000; p_reg[0] = 1'b0; p_init[0] = 1'b0;
    p_tt[1] = 32'h6996_9669; p_reg[1] = 1'b1; p_init[1] = 1'b1;
    do_load(0, 1'b0, 1'b0);
    check_eq("init_slice1", 32'(lut_out[1]), 32'd1);
    lut_in = {10'h0, 5'h01, 5'h1F};
    ce     = 1'b1;
    #1;
    check_eq("and5_all_ones", 32'(lut_out[0]), 32'd1);
    tick();
    check_eq("reg_slice_update", 32'(lut_out[1]), 32'd0);
    lut_in = {10'h0, 5'h03, 5'h1E};
    ce     = 1'b0;
    #1;
    check_eq("and5_one_zero", 32'(lut_out[0]), 32'd0);
    tick();
    check_eq("reg_slice_hold", 32'(lut_out[1]), 32'd0);
    check_eq("directed_full", 32'(lut_out), 32'(model_out()));
    run_random(150);

    // Abort after 30 beats, then reload with stalls and a start+valid collision
    randomize_cfg();
    ce        = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    m_active  = 1'b0;
    raw_beats(30);
    check_eq("partial_done", 32'(cfg_done), 32'd0);
    check_eq("partial_err", 32'(cfg_err), 32'd0);
    do_load(30, 1'b1, 1'b1);
    run_random(150);

    // Reset mid-load discards progress and clears the sticky error
    ce        = 1'b0;
    cfg_start = 1'b1;
    tick();
    m_active  = 1'b0;
    raw_beats(5);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check_eq("abort_err", 32'(cfg_err), 32'd1);
    raw_beats(5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_ff  = '0;
    check_eq("midrst_ready", 32'(cfg_ready), 32'd0);
    check_eq("midrst_err", 32'(cfg_err), 32'd0);
    check_eq("midrst_done", 32'(cfg_done), 32'd0);
    randomize_cfg();
    do_load(50, 1'b1, 1'b0);
    run_random(100);

`ifdef CFG_READBACK_EN
    for (int i = 0; i < 136; i += 32) patt[i +: 8] = 8'($urandom);
    for (int i = 0; i < 136; i++) patt[i] = 1'($urandom);
    ce = 1'b0;
    // Fill A with the first half of the pattern
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 68; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = patt[i*2 +: 2];
      tick();
    end
    cfg_valid = 1'b0;
    // Push the second half through A into B
    cfg_start = 1'b1;
    start_b   = 1'b1;
    tick();
    cfg_start = 1'b0;
    start_b   = 1'b0;
    for (int i = 0; i < 68; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = patt[(68+i)*2 +: 2];
      #1;
      check_eq("chain_dout_a", 32'(dout_a), 32'(patt[i*2 +: 2]));
      tick();
    end
    cfg_valid = 1'b0;
    check_eq("chain_done_a", 32'(cfg_done), 32'd1);
    check_eq("chain_done_b", 32'(done_b), 32'd1);
    // Drain both clusters to read back their contents
    cfg_start = 1'b1;
    start_b   = 1'b1;
    tick();
    cfg_start = 1'b0;
    start_b   = 1'b0;
    for (int i = 0; i < 68; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 2'b00;
      #1;
      check_eq("readback_a", 32'(dout_a), 32'(patt[(68+i)*2 +: 2]));
      check_eq("readback_b", 32'(dout_b), 32'(patt[i*2 +: 2]));
      tick();
    end
    cfg_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
